// File: rtl/dvi_pkg.sv
// Shared widths, default 640x480 timing and lock-FSM states for the DVI sink decoder.
// Also holds the CRC polynomial and a saturating coordinate increment helper.
package dvi_pkg;

  localparam int CORDW       = 10;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int H_TOTAL     = 800;
  localparam int LOCK_FRAMES = 2;

  localparam logic [CORDW-1:0] COR_MAX  = '1;
  localparam logic [15:0]      CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } sync_state_e;

  function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
    return (v == COR_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dvi_crc16.sv
// One CRC-16-CCITT step over a 12-bit {r,g,b} word, MSB first, purely combinational.
module dvi_crc16
  import dvi_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [11:0] data_i,
  output logic [15:0] crc_o
);

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [11:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

  assign crc_o = crc_step(crc_i, data_i);

endmodule

// File: rtl/dvi_sync_decoder.sv
// DVI sink: recovers pixel coordinates, frame strobes and timing lock from hsync/vsync/de/RGB.
// Define DVI_CRC_EN to build the per-frame CRC-16 over active pixels.
module dvi_sync_decoder
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE_P    = H_ACTIVE,
  parameter int V_ACTIVE_P    = V_ACTIVE,
  parameter int H_TOTAL_P     = H_TOTAL,
  parameter int LOCK_FRAMES_P = LOCK_FRAMES,
  parameter int HSYNC_POL_P   = 0,
  parameter int VSYNC_POL_P   = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             de_i,
  input  logic [3:0]       r_i,
  input  logic [3:0]       g_i,
  input  logic [3:0]       b_i,
  output logic             pix_valid_o,
  output logic [CORDW-1:0] sx_o,
  output logic [CORDW-1:0] sy_o,
  output logic [3:0]       pix_r_o,
  output logic [3:0]       pix_g_o,
  output logic [3:0]       pix_b_o,
  output logic             frame_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [CORDW-1:0] h_total_o,
  output logic [CORDW-1:0] lines_o,
  output logic [15:0]      crc_o,
  output logic             crc_valid_o
);

  localparam logic [CORDW-1:0] H_ACT_C  = CORDW'(H_ACTIVE_P);
  localparam logic [CORDW-1:0] V_ACT_C  = CORDW'(V_ACTIVE_P);
  localparam logic [CORDW-1:0] H_TOT_C  = CORDW'(H_TOTAL_P);
  localparam logic [7:0]       LOCK_C   = 8'(LOCK_FRAMES_P);
  localparam logic             HS_POL_C = 1'(HSYNC_POL_P);
  localparam logic             VS_POL_C = 1'(VSYNC_POL_P);

  logic hs_act, vs_act, hs_edge, vs_edge, de_rise, de_fall;
  logic hs_act_q, vs_act_q, de_q;

  logic [CORDW-1:0] hcnt_q, hcnt_d, width_q, width_d;
  logic [CORDW-1:0] line_cnt_q, line_cnt_d, line_cnt_inc;
  logic             h_seen_q, h_seen_d, bad_q, bad_d, bad_now, frame_bad;

  logic             pix_valid_q, frame_q;
  logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d, h_total_q, h_total_d, lines_q, lines_d;
  logic [3:0]       pix_r_q, pix_g_q, pix_b_q;

  sync_state_e      state_q, state_d;
  logic [7:0]       good_q, good_d, good_inc;
  logic             locked_q, locked_d, err_q, err_d;

  assign hs_act  = (hsync_i == HS_POL_C);
  assign vs_act  = (vsync_i == VS_POL_C);
  assign hs_edge = hs_act & ~hs_act_q;
  assign vs_edge = vs_act & ~vs_act_q;
  assign de_rise = de_i & ~de_q;
  assign de_fall = ~de_i & de_q;

  // Line and frame measurement; the h_total check waits for a first reference edge.
  always_comb begin
    hcnt_d       = hs_edge ? CORDW'(1) : sat_inc(hcnt_q);
    h_seen_d     = h_seen_q | hs_edge;
    h_total_d    = (hs_edge && h_seen_q) ? hcnt_q : h_total_q;
    width_d      = de_i ? (de_rise ? CORDW'(1) : sat_inc(width_q)) : width_q;
    line_cnt_inc = de_fall ? sat_inc(line_cnt_q) : line_cnt_q;
    line_cnt_d   = vs_edge ? '0 : line_cnt_inc;
    lines_d      = vs_edge ? line_cnt_inc : lines_q;
    bad_now      = (de_fall && (width_q != H_ACT_C))
                 | (hs_edge && h_seen_q && (hcnt_q != H_TOT_C))
                 | (de_i && vs_act);
    frame_bad    = bad_q | bad_now | (line_cnt_inc != V_ACT_C);
    bad_d        = vs_edge ? 1'b0 : (bad_q | bad_now);
    sx_d         = de_i ? (de_rise ? '0 : sat_inc(sx_q)) : sx_q;
    sy_d         = de_i ? line_cnt_q : sy_q;
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    locked_d = locked_q;
    err_d    = err_q;
    good_inc = good_q + 8'd1;
    if (vs_edge) begin
      unique case (state_q)
        SEARCH: begin
          state_d = TRACK;
          good_d  = '0;
        end
        TRACK: begin
          if (frame_bad) begin
            good_d = '0;
          end else begin
            good_d = good_inc;
            if (good_inc >= LOCK_C) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (frame_bad) begin
            state_d  = TRACK;
            good_d   = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hs_act_q    <= 1'b0;
      vs_act_q    <= 1'b0;
      de_q        <= 1'b0;
      hcnt_q      <= '0;
      width_q     <= '0;
      line_cnt_q  <= '0;
      h_seen_q    <= 1'b0;
      bad_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      frame_q     <= 1'b0;
      sx_q        <= '0;
      sy_q        <= '0;
      pix_r_q     <= '0;
      pix_g_q     <= '0;
      pix_b_q     <= '0;
      h_total_q   <= '0;
      lines_q     <= '0;
      state_q     <= SEARCH;
      good_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      hs_act_q    <= hs_act;
      vs_act_q    <= vs_act;
      de_q        <= de_i;
      hcnt_q      <= hcnt_d;
      width_q     <= width_d;
      line_cnt_q  <= line_cnt_d;
      h_seen_q    <= h_seen_d;
      bad_q       <= bad_d;
      pix_valid_q <= de_i;
      frame_q     <= vs_edge;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      pix_r_q     <= r_i;
      pix_g_q     <= g_i;
      pix_b_q     <= b_i;
      h_total_q   <= h_total_d;
      lines_q     <= lines_d;
      state_q     <= state_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign pix_valid_o = pix_valid_q;
  assign sx_o        = sx_q;
  assign sy_o        = sy_q;
  assign pix_r_o     = pix_r_q;
  assign pix_g_o     = pix_g_q;
  assign pix_b_o     = pix_b_q;
  assign frame_o     = frame_q;
  assign locked_o    = locked_q;
  assign err_o       = err_q;
  assign h_total_o   = h_total_q;
  assign lines_o     = lines_q;

`ifdef DVI_CRC_EN
  localparam logic [15:0] CRC_INIT_C = 16'hFFFF;

  logic [15:0] crc_acc_q, crc_acc_d, crc_step, crc_cur, crc_out_q;
  logic        crc_valid_q;

  dvi_crc16 u_crc (
    .crc_i  (crc_acc_q),
    .data_i ({r_i, g_i, b_i}),
    .crc_o  (crc_step)
  );

  // A de cycle coinciding with the frame edge still belongs to the closing frame.
  assign crc_cur   = de_i ? crc_step : crc_acc_q;
  assign crc_acc_d = vs_edge ? CRC_INIT_C : crc_cur;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      crc_acc_q   <= CRC_INIT_C;
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_acc_q   <= crc_acc_d;
      crc_valid_q <= vs_edge;
      if (vs_edge) begin
        crc_out_q <= crc_cur;
      end
    end
  end

  assign crc_o       = crc_out_q;
  assign crc_valid_o = crc_valid_q;
`else
  assign crc_o       = '0;
  assign crc_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_dvi_sync_decoder.sv
// Scoreboard bench for dvi_sync_decoder on a reduced raster with randomized colours and faults.
module tb_dvi_sync_decoder;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VA = 6, VS = 2, VBP = 2, VFP = 2;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int LOCK = 2;
  localparam int FIRST_ACT = VS + VBP;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        hsync_i = 1'b1, vsync_i = 1'b1, de_i = 1'b0;
  logic [3:0]  r_i = '0, g_i = '0, b_i = '0;
  logic        pix_valid_o, frame_o, locked_o, err_o, crc_valid_o;
  logic [9:0]  sx_o, sy_o, h_total_o, lines_o;
  logic [3:0]  pix_r_o, pix_g_o, pix_b_o;
  logic [15:0] crc_o;

  always #5 clk = ~clk;

  dvi_sync_decoder #(
    .H_ACTIVE_P(HA), .V_ACTIVE_P(VA), .H_TOTAL_P(HT),
    .LOCK_FRAMES_P(LOCK), .HSYNC_POL_P(0), .VSYNC_POL_P(0)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i), .pix_valid_o(pix_valid_o), .sx_o(sx_o), .sy_o(sy_o),
    .pix_r_o(pix_r_o), .pix_g_o(pix_g_o), .pix_b_o(pix_b_o), .frame_o(frame_o),
    .locked_o(locked_o), .err_o(err_o), .h_total_o(h_total_o), .lines_o(lines_o),
    .crc_o(crc_o), .crc_valid_o(crc_valid_o)
  );

  typedef struct packed {
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic [11:0] rgb;
  } pix_t;

  typedef struct packed {
    logic [9:0]  lines;
    logic [9:0]  h_total;
    logic        locked;
    logic        err;
    logic [15:0] crc;
    logic        crc_valid;
  } frm_t;

  pix_t pix_q[$];
  frm_t frm_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_frames = 0;

  // Reference model state: sync/lock bookkeeping plus per-frame tallies.
  bit          m_seen, m_locked, m_err, m_in_run, m_faulty;
  int          m_good, m_runs, m_pos;
  logic [15:0] m_crc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [11:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 4'h0};
    for (int k = 0; k < 12; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic model_reset();
    m_seen = 0; m_locked = 0; m_err = 0; m_good = 0;
    m_runs = 0; m_pos = 0; m_in_run = 0; m_faulty = 0; m_crc = 16'hFFFF;
  endtask

  task automatic push_frame_expect();
    frm_t f;
    bit   bad;
    bad = m_faulty || (m_runs != VA);
    if (!m_seen) begin
      m_seen = 1; m_good = 0;
    end else if (bad) begin
      if (m_locked) m_err = 1;
      m_locked = 0; m_good = 0;
    end else begin
      m_good++;
      if (m_good >= LOCK) m_locked = 1;
    end
    f.lines   = 10'(m_runs);
    f.h_total = 10'(HT);
    f.locked  = m_locked;
    f.err     = m_err;
`ifdef DVI_CRC_EN
    f.crc = m_crc; f.crc_valid = 1'b1;
`else
    f.crc = 16'h0; f.crc_valid = 1'b0;
`endif
    frm_q.push_back(f);
    m_runs = 0; m_faulty = 0; m_crc = 16'hFFFF;
  endtask

  task automatic model_cycle(input bit de, input logic [11:0] rgb);
    pix_t p;
    if (de) begin
      if (!m_in_run) begin m_in_run = 1; m_pos = 0; end
      p.sx = 10'(m_pos); p.sy = 10'(m_runs); p.rgb = rgb;
      pix_q.push_back(p);
      m_crc = crc_upd(m_crc, rgb);
      m_pos++;
    end else if (m_in_run) begin
      m_in_run = 0; m_runs++;
    end
  endtask

  task automatic check_zero();
    check("rst_pix_valid", 32'(pix_valid_o), 0);
    check("rst_frame",     32'(frame_o), 0);
    check("rst_locked",    32'(locked_o), 0);
    check("rst_err",       32'(err_o), 0);
    check("rst_sx_sy",     {12'h0, sx_o, sy_o}, 0);
    check("rst_rgb",       32'({pix_r_o, pix_g_o, pix_b_o}), 0);
    check("rst_h_total",   32'(h_total_o), 0);
    check("rst_lines",     32'(lines_o), 0);
    check("rst_crc",       {15'h0, crc_valid_o, crc_o}, 0);
  endtask

  // fault: 0 none, 1 short active line, 2 de during vsync, 3 missing last active line
  task automatic drive_frame(input int fault, input int rst_line, input bit const_col, input bit do_push);
    logic [11:0] rgb;
    bit          de, inj;
    for (int l = 0; l < VT; l++) begin
      for (int c = 0; c < HT; c++) begin
        if (do_push && l == 0 && c == 0) push_frame_expect();
        if (l == rst_line && c < 4) reset_i = 1'b1;
        if (l == rst_line && c == 4) begin
          check_zero();
          reset_i = 1'b0;
          model_reset();
        end
        de  = (l >= FIRST_ACT) && (l < FIRST_ACT + VA) && (c < HA);
        inj = 0;
        if (fault == 1 && l == FIRST_ACT + 2 && c == HA - 1) begin de = 0; inj = 1; end
        if (fault == 3 && l == FIRST_ACT + VA - 1) de = 0;
        if (fault == 2 && l == 1 && c < 4) begin de = 1; inj = 1; end
        if (inj && !reset_i) m_faulty = 1;
        rgb     = const_col ? 12'hF00 : 12'($urandom_range(0, 4095));
        hsync_i = !(c >= HA + HFP && c < HA + HFP + HS);
        vsync_i = !(l < VS);
        de_i    = de;
        r_i     = rgb[11:8];
        g_i     = rgb[7:4];
        b_i     = rgb[3:0];
        if (!reset_i) model_cycle(de, rgb);
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a pixel or a frame strobe.
  always @(negedge clk) begin
    if (pix_valid_o) begin
      if (pix_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pixel_unexpected: got sx=%0d sy=%0d, expected no pixel", sx_o, sy_o);
      end else begin
        pix_t e;
        e = pix_q.pop_front();
        check("pixel{sx,sy,rgb}", {sx_o, sy_o, pix_r_o, pix_g_o, pix_b_o}, e);
      end
    end
    if (frame_o) begin
      if (frm_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL frame_unexpected: got frame_o=1, expected none");
      end else begin
        frm_t f;
        f = frm_q.pop_front();
        n_frames++;
        $display("[TB] frame %0d: lines=%0d h_total=%0d locked=%0d err=%0d crc=%h",
                 n_frames, lines_o, h_total_o, locked_o, err_o, crc_o);
        check("frame_lines",   32'(lines_o), 32'(f.lines));
        check("frame_h_total", 32'(h_total_o), 32'(f.h_total));
        check("frame_locked",  32'(locked_o), 32'(f.locked));
        check("frame_err",     32'(err_o), 32'(f.err));
        check("frame_crc",     {15'h0, crc_valid_o, crc_o}, {15'h0, f.crc_valid, f.crc});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    int f;
    model_reset();
    @(posedge clk);
    #1;
    drive_frame(0, 10, 0, 0);
    drive_frame(0, -1, 0, 1);
    drive_frame(0, -1, 0, 1);
    drive_frame(0, -1, 0, 1);
    drive_frame(1, -1, 0, 1);
    drive_frame(0, -1, 0, 1);
    drive_frame(0, -1, 0, 1);
    drive_frame(0, -1, 0, 1);
    drive_frame(0, 10, 0, 1);
    drive_frame(2, -1, 0, 1);
    drive_frame(0, -1, 0, 1);
    drive_frame(0, -1, 0, 1);
    drive_frame(0, -1, 0, 1);
    drive_frame(0, -1, 1, 1);
    for (int i = 0; i < 16; i++) begin
      f = int'($urandom_range(0, 5));
      if (f > 3) f = 0;
      drive_frame(f, -1, 0, 1);
    end
    drive_frame(0, -1, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("pixel_queue_drained", 32'(pix_q.size()), 0);
    check("frame_queue_drained", 32'(frm_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
